// File: rtl/tt_um_hoene_frame_sequencer.sv
// tt_um_hoene_frame_sequencer
//
// Frame-level controller between the Manchester decoder and the downstream consumers.
// The first FRAME_BITS bits of each burst form this LED's own frame. They are shifted into
// serial2parallel, followed by a store pulse and a pwm_set pulse. Every later bit of the same
// burst is forwarded to the encoder for the next LED in the chain. An idle gap of IDLE_CYCLES
// clocks ends a burst. A decoder error parks the block in ERROR until that gap.
//
// Optional feature macro: FRAME_SEQ_PARITY_EN
//   defined   -> even parity over the own frame; a mismatch sets error and drops store/pwm_set
//   undefined -> no parity accumulator; store/pwm_set always follow a complete own frame
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   in_data, in_clk       decoded bit and its single-cycle strobe
//   in_error              decoder error pulse
//   shift_data/shift_clk  own-frame bit and strobe to serial2parallel
//   store, pwm_set        latch pulse and PWM update pulse
//   fwd_data/fwd_clk      forwarded bit and strobe to the encoder
//   fwd_enable            encoder output enable
//   bit_count             own-frame bits received in the current burst
//   state                 0=IDLE 1=OWN 2=FORWARD 3=ERROR
//   error                 sticky frame error, cleared by the next frame start
module tt_um_hoene_frame_sequencer #(
    parameter int unsigned FRAME_BITS  = 32,
    parameter int unsigned IDLE_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_data,
    input  logic       in_clk,
    input  logic       in_error,
    output logic       shift_data,
    output logic       shift_clk,
    output logic       store,
    output logic       pwm_set,
    output logic       fwd_data,
    output logic       fwd_clk,
    output logic       fwd_enable,
    output logic [5:0] bit_count,
    output logic [1:0] state,
    output logic       error
);

    localparam int unsigned IdleW = $clog2(IDLE_CYCLES + 1);
    localparam logic [IdleW-1:0] IdleMax = IdleW'(IDLE_CYCLES);
    localparam logic [5:0] FrameMax = 6'(FRAME_BITS);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StOwn     = 2'd1;
    localparam logic [1:0] StForward = 2'd2;
    localparam logic [1:0] StError   = 2'd3;

    logic [1:0]       r_state,   w_state_d;
    logic [5:0]       r_count,   w_count_d;
    logic             r_error,   w_error_d;
    logic             r_sdata,   w_sdata_d;
    logic             r_sclk,    w_sclk_d;
    logic             r_fdata,   w_fdata_d;
    logic             r_fclk,    w_fclk_d;
    logic             r_fen;
    logic [IdleW-1:0] r_idle_cnt;
    // Store/PWM pipeline: r_pend one cycle after the last own bit, r_store the cycle after.
    logic             r_pend,    w_pend_d;
    logic             r_store;
    logic             r_pwm_ok;
    logic             r_pwm;
    logic             w_timeout;
    logic             w_last_bit;
    logic             w_par_ok;
`ifdef FRAME_SEQ_PARITY_EN
    logic             r_parity,  w_parity_d;
`endif

    assign w_timeout  = (r_idle_cnt == IdleMax) && (r_state != StIdle);
    assign w_last_bit = (r_count == FrameMax - 6'd1);

`ifdef FRAME_SEQ_PARITY_EN
    // Even parity: accumulated parity of the earlier bits must equal the last bit.
    assign w_par_ok = ~(r_parity ^ in_data);
`else
    assign w_par_ok = 1'b1;
`endif

    always_comb begin
        w_state_d = r_state;
        w_count_d = r_count;
        w_error_d = r_error;
        w_sdata_d = r_sdata;
        w_sclk_d  = 1'b0;
        w_fdata_d = r_fdata;
        w_fclk_d  = 1'b0;
        w_pend_d  = 1'b0;
`ifdef FRAME_SEQ_PARITY_EN
        w_parity_d = r_parity;
`endif
        unique case (r_state)
            StIdle: begin
                if (in_clk && !in_error) begin
                    w_state_d = StOwn;
                    w_count_d = 6'd1;
                    w_error_d = 1'b0;
                    w_sdata_d = in_data;
                    w_sclk_d  = 1'b1;
`ifdef FRAME_SEQ_PARITY_EN
                    w_parity_d = in_data;
`endif
                end
            end
            StOwn: begin
                if (in_error) begin
                    w_state_d = StError;
                    w_error_d = 1'b1;
                end else if (w_timeout) begin
                    // Truncated frame
                    w_state_d = StIdle;
                    w_error_d = 1'b1;
                end else if (in_clk) begin
                    w_count_d = r_count + 6'd1;
                    w_sdata_d = in_data;
                    w_sclk_d  = 1'b1;
`ifdef FRAME_SEQ_PARITY_EN
                    w_parity_d = r_parity ^ in_data;
`endif
                    if (w_last_bit) begin
                        w_state_d = StForward;
                        if (w_par_ok) begin
                            w_pend_d = 1'b1;
                        end else begin
                            w_error_d = 1'b1;
                        end
                    end
                end
            end
            StForward: begin
                if (in_error) begin
                    w_state_d = StError;
                    w_error_d = 1'b1;
                end else if (w_timeout) begin
                    w_state_d = StIdle;
                end else if (in_clk) begin
                    w_fdata_d = in_data;
                    w_fclk_d  = 1'b1;
                end
            end
            StError: begin
                if (w_timeout) begin
                    w_state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_count    <= 6'd0;
            r_error    <= 1'b0;
            r_sdata    <= 1'b0;
            r_sclk     <= 1'b0;
            r_fdata    <= 1'b0;
            r_fclk     <= 1'b0;
            r_fen      <= 1'b0;
            r_idle_cnt <= '0;
            r_pend     <= 1'b0;
            r_store    <= 1'b0;
            r_pwm_ok   <= 1'b0;
            r_pwm      <= 1'b0;
`ifdef FRAME_SEQ_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_d;
            r_count <= w_count_d;
            r_error <= w_error_d;
            r_sdata <= w_sdata_d;
            r_sclk  <= w_sclk_d;
            r_fdata <= w_fdata_d;
            r_fclk  <= w_fclk_d;
            // Follows the next state so it drops together with the FORWARD exit.
            r_fen   <= (w_state_d == StForward);
            if (in_clk) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != IdleMax) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
            // store is committed once pending; pwm_set is vetoed by an error in either
            // of the two cycles before it.
            r_pend   <= w_pend_d;
            r_store  <= r_pend;
            r_pwm_ok <= r_pend & ~in_error;
            r_pwm    <= r_pwm_ok & ~in_error;
`ifdef FRAME_SEQ_PARITY_EN
            r_parity <= w_parity_d;
`endif
        end
    end

    assign shift_data = r_sdata;
    assign shift_clk  = r_sclk;
    assign store      = r_store;
    assign pwm_set    = r_pwm;
    assign fwd_data   = r_fdata;
    assign fwd_clk    = r_fclk;
    assign fwd_enable = r_fen;
    assign bit_count  = r_count;
    assign state      = r_state;
    assign error      = r_error;

endmodule

// File: tb/tb_tt_um_hoene_frame_sequencer.sv
module tb_tt_um_hoene_frame_sequencer;

    localparam int unsigned FB = 32;
    localparam int unsigned IC = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_data = 1'b0;
    logic in_clk = 1'b0;
    logic in_error = 1'b0;
    logic shift_data, shift_clk, store, pwm_set, fwd_data, fwd_clk, fwd_enable, error;
    logic [5:0] bit_count;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;

    tt_um_hoene_frame_sequencer #(.FRAME_BITS(FB), .IDLE_CYCLES(IC)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_clk(in_clk), .in_error(in_error),
        .shift_data(shift_data), .shift_clk(shift_clk), .store(store), .pwm_set(pwm_set),
        .fwd_data(fwd_data), .fwd_clk(fwd_clk), .fwd_enable(fwd_enable),
        .bit_count(bit_count), .state(state), .error(error)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Mode names follow the state output encoding: 0 idle, 1 own, 2 forward, 3 error.
    int          m_mode = 0;
    int          m_idle = 0;
    int          m_count = 0;
    logic [63:0] m_frame = '0;
    bit          m_err = 0;
    longint      cyc = 0;
    longint      store_at = -10;
    longint      pwm_at = -10;
    longint      last_clk_cyc = 0;
    bit e_sdata = 0, e_sclk = 0, e_store = 0, e_pwm = 0, e_fdata = 0, e_fclk = 0, e_fen = 0;

    function automatic bit frame_ok(input logic [63:0] f);
`ifdef FRAME_SEQ_PARITY_EN
        return ($countones(f) % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_step();
        bit tmo;
        if (!rst_n) begin
            m_mode = 0; m_idle = 0; m_count = 0; m_frame = '0; m_err = 0;
            store_at = -10; pwm_at = -10;
            e_sdata = 0; e_sclk = 0; e_store = 0; e_pwm = 0;
            e_fdata = 0; e_fclk = 0; e_fen = 0;
            return;
        end
        cyc++;
        tmo = (m_idle == IC) && (m_mode != 0);
        e_sclk = 0;
        e_fclk = 0;
        if (in_error && (cyc == pwm_at - 1 || cyc == pwm_at)) pwm_at = -10;
        e_store = (cyc == store_at);
        e_pwm = (cyc == pwm_at);
        if (in_clk) last_clk_cyc = cyc;
        case (m_mode)
            0: if (in_clk && !in_error) begin
                m_mode = 1; m_count = 1; m_err = 0;
                m_frame = '0; m_frame[0] = in_data;
                e_sclk = 1; e_sdata = in_data;
            end
            1: if (in_error) begin
                m_mode = 3; m_err = 1;
            end else if (tmo) begin
                m_mode = 0; m_err = 1;
            end else if (in_clk) begin
                m_frame[m_count] = in_data;
                m_count++;
                e_sclk = 1; e_sdata = in_data;
                if (m_count == FB) begin
                    m_mode = 2;
                    if (frame_ok(m_frame)) begin
                        store_at = cyc + 1;
                        pwm_at = cyc + 2;
                    end else begin
                        m_err = 1;
                    end
                end
            end
            2: if (in_error) begin
                m_mode = 3; m_err = 1;
            end else if (tmo) begin
                m_mode = 0;
            end else if (in_clk) begin
                e_fclk = 1; e_fdata = in_data;
            end
            default: if (tmo) m_mode = 0;
        endcase
        m_idle = in_clk ? 0 : ((m_idle < IC) ? m_idle + 1 : IC);
        e_fen = (m_mode == 2);
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Event monitor used by the directed literal checks.
    int          n_shift = 0, n_store = 0, n_pwm = 0, n_fwd = 0;
    longint      store_cyc = -1, pwm_cyc = -1, drop_cyc = -1;
    logic [15:0] fwd_bits = '0;
    bit          prev_fen = 0;

    task automatic clear_mon();
        n_shift = 0; n_store = 0; n_pwm = 0; n_fwd = 0;
        store_cyc = -1; pwm_cyc = -1; drop_cyc = -1; fwd_bits = '0;
    endtask

    initial forever begin
        @(negedge clk);
        chk("shift_clk", shift_clk, e_sclk);
        chk("shift_data", shift_data, e_sdata);
        chk("store", store, e_store);
        chk("pwm_set", pwm_set, e_pwm);
        chk("fwd_clk", fwd_clk, e_fclk);
        chk("fwd_data", fwd_data, e_fdata);
        chk("fwd_enable", fwd_enable, e_fen);
        chk("bit_count", bit_count, m_count);
        chk("state", state, m_mode);
        chk("error", error, m_err);
        if (shift_clk === 1'b1) n_shift++;
        if (store === 1'b1) begin n_store++; store_cyc = cyc; end
        if (pwm_set === 1'b1) begin n_pwm++; pwm_cyc = cyc; end
        if (fwd_clk === 1'b1) begin n_fwd++; fwd_bits = {fwd_bits[14:0], fwd_data}; end
        if (prev_fen && fwd_enable !== 1'b1) drop_cyc = cyc;
        prev_fen = (fwd_enable === 1'b1);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input bit d, input int gap, input bit err);
        in_clk = 1; in_data = d; in_error = err;
        tick();
        in_clk = 0; in_error = 0;
        repeat (gap - 1) tick();
    endtask

    // Sends the n low bits of w, most significant first.
    task automatic send_word(input logic [63:0] w, input int n, input int gap);
        logic [63:0] v;
        v = w;
        for (int i = n - 1; i >= 0; i--) send_bit(v[i], gap, 1'b0);
    endtask

    function automatic logic [31:0] good_frame(input logic [30:0] r);
        return {r, ^r};
    endfunction

    logic [31:0] fr;

    initial begin
        #1 rst_n = 0;
        repeat (3) tick();
        rst_n = 1;
        tick();

        // 1: all-zero frame, strobe every 8 cycles
        clear_mon();
        send_word(64'h0, 32, 8);
        repeat (4) tick();
        chk("t1_shift_count", n_shift, 32);
        chk("t1_store_count", n_store, 1);
        chk("t1_store_latency", store_cyc - last_clk_cyc, 1);
        chk("t1_pwm_latency", pwm_cyc - last_clk_cyc, 2);
        chk("t1_state", state, 2);
        chk("t1_error", error, 0);
        repeat (IC + 5) tick();

        // 2: good own frame then 0xA5C3 forwarded
        fr = good_frame(31'($urandom));
        clear_mon();
        send_word({32'h0, fr}, 32, 3);
        send_word(64'hA5C3, 16, 3);
        repeat (IC + 5) tick();
        chk("t2_fwd_count", n_fwd, 16);
        chk("t2_fwd_bits", fwd_bits, 16'hA5C3);
        chk("t2_fen_drop", drop_cyc - last_clk_cyc, IC + 1);
        chk("t2_state", state, 0);

        // 3: odd-parity frame 0x00000001 then 8 forwarded bits
        clear_mon();
        send_word({32'h1, 8'hFF}, 40, 4);
        repeat (4) tick();
        chk("t3_fwd_count", n_fwd, 8);
`ifdef FRAME_SEQ_PARITY_EN
        chk("t3_store_count", n_store, 0);
        chk("t3_pwm_count", n_pwm, 0);
        chk("t3_error", error, 1);
`else
        chk("t3_store_count", n_store, 1);
        chk("t3_error", error, 0);
`endif
        repeat (IC + 5) tick();

        // 4: truncated frame, then a valid frame recovers
        clear_mon();
        send_word(64'hABCDE, 20, 2);
        repeat (IC + 5) tick();
        chk("t4_trunc_error", error, 1);
        chk("t4_trunc_state", state, 0);
        chk("t4_trunc_store", n_store, 0);
        send_word({32'h0, good_frame(31'h1234567)}, 32, 2);
        repeat (4) tick();
        chk("t4_recover_error", error, 0);
        chk("t4_recover_store", n_store, 1);
        repeat (IC + 5) tick();

        // 5: in_error together with the 40th strobe
        send_word({32'h0, good_frame(31'h55AA55A)}, 32, 2);
        send_word(64'h5A, 7, 2);
        clear_mon();
        send_bit(1'b1, 3, 1'b1);
        chk("t5_state", state, 3);
        chk("t5_fen", fwd_enable, 0);
        send_word(64'h1F, 5, 4);
        chk("t5_fwd_count", n_fwd, 0);
        repeat (IC + 5) tick();
        chk("t5_end_state", state, 0);
        chk("t5_end_error", error, 1);

        // 6: reset in the cycle after the 32nd strobe
        clear_mon();
        fr = good_frame(31'h7FFF0001);
        for (int i = 31; i >= 1; i--) send_bit(fr[i], 2, 1'b0);
        in_clk = 1; in_data = fr[0];
        tick();
        in_clk = 0;
        rst_n = 0;
        #1;
        chk("t6_outputs", {shift_data, shift_clk, store, pwm_set, fwd_data, fwd_clk,
                           fwd_enable, bit_count, state, error}, 0);
        repeat (2) tick();
        rst_n = 1;
        repeat (5) tick();
        chk("t6_store_count", n_store, 0);
        chk("t6_pwm_count", n_pwm, 0);
        chk("t6_state", state, 0);

        // Random bursts
        for (int b = 0; b < 60; b++) begin
            int len;
            logic [31:0] own;
            len = $urandom_range(1, 60);
            own = $urandom;
            if ($urandom_range(0, 1) == 1) own = good_frame(own[31:1]);
            for (int i = 0; i < len; i++) begin
                bit d;
                bit e;
                d = (i < 32) ? own[31 - i] : 1'($urandom);
                e = ($urandom_range(0, 49) == 0);
                if ($urandom_range(0, 199) == 0) begin
                    rst_n = 0;
                    tick();
                    rst_n = 1;
                end
                send_bit(d, $urandom_range(1, 6), e);
            end
            repeat ($urandom_range(IC - 3, IC + 10)) tick();
        end
        repeat (IC + 5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tt_um_hoene_frame_sequencer.md
Name: tt_um_hoene_frame_sequencer

Overview:
Frame-level controller between the Manchester decoder (with its low-pass and input-select front end) and the downstream consumers: serial2parallel/led_pwm and the Manchester encoder.
- Consumes the first FRAME_BITS bits of each burst as this LED's own frame.
- Commands the shift register to store and the PWM to update.
- Forwards every later bit of the burst to the encoder for the next LED in the chain.
- An end-of-burst idle gap or a decoder error resequences the block.

Parameters:
FRAME_BITS, 32, bits consumed per own frame (2..63)
IDLE_CYCLES, 64, clk cycles without in_clk that end a burst (2..255)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
in_data  input  1  decoded bit; valid when in_clk=1
in_clk  input  1  single-cycle bit strobe from the decoder
in_error  input  1  decoder error pulse
shift_data  output  1  bit to serial2parallel
shift_clk  output  1  single-cycle shift strobe
store  output  1  single-cycle latch pulse to serial2parallel
pwm_set  output  1  single-cycle PWM update pulse
fwd_data  output  1  bit to the encoder
fwd_clk  output  1  single-cycle forward strobe
fwd_enable  output  1  encoder output enable
bit_count  output  6  own-frame bits received in the current burst
state  output  2  0=IDLE 1=OWN 2=FORWARD 3=ERROR
error  output  1  sticky frame error

Behaviour:
- Clocking and reset
  - All outputs are registered.
  - Reset: every output is 0, state=IDLE, the idle counter and the parity accumulator are 0.
  - Reset is honoured mid-frame: no store or pwm_set pulse is emitted after reset.
- Idle counter
  - Clears on every in_clk.
  - Otherwise increments, saturating at IDLE_CYCLES.
  - "timeout" means the counter equals IDLE_CYCLES while state is not IDLE.
- IDLE
  - On in_clk (and in_error=0): go to OWN, bit_count=1, clear error, parity=in_data.
  - The bit is shifted: shift_data=in_data and shift_clk=1 in the next cycle (1-cycle latency).
- OWN
  - Each in_clk: bit_count+1, parity^=in_data, shift strobe with 1-cycle latency.
  - When the FRAME_BITS-th bit is accepted at cycle T: shift_clk at T+1, store at T+2, pwm_set at T+3, then state=FORWARD.
  - Parity is even over all FRAME_BITS bits, so the last bit is the parity bit.
  - Parity mismatch: no store, no pwm_set, error=1, state=FORWARD. The burst is still forwarded.
  - Timeout with bit_count<FRAME_BITS: truncated frame. error=1, no store, state=IDLE.
- FORWARD
  - fwd_enable=1 for the whole state.
  - Each in_clk gives fwd_data=in_data and fwd_clk=1 one cycle later.
  - bit_count holds at FRAME_BITS.
  - Timeout: state=IDLE, fwd_enable=0 in the same cycle as the state change.
- ERROR
  - Entered from OWN or FORWARD on in_error=1.
  - error=1, fwd_enable=0. All in_clk are ignored: no shift, no fwd, no store.
  - Timeout: state=IDLE, error stays set until the next frame start.
  - in_error while IDLE is ignored.
- Simultaneous events
  - in_clk together with in_error: error wins and the bit is discarded.
  - A store pulse already scheduled at T+2 still fires if in_error arrives at T+1. pwm_set at T+3 is suppressed if in_error arrives at T+1 or T+2.
- Strobe spacing
  - in_clk pulses closer than 4 cycles are legal.
  - store/pwm_set timing is relative only to the last own bit.
  - Forward strobes pass through one per in_clk with no loss.
- Width rules
  - bit_count never wraps: it saturates at FRAME_BITS.
  - Idle counter width is ceil(log2(IDLE_CYCLES+1)).

Optional Feature:
FRAME_SEQ_PARITY_EN
- Defined: even-parity check as described; a mismatch sets error and suppresses store/pwm_set.
- Undefined: the parity accumulator is removed. store and pwm_set always fire after FRAME_BITS bits, and error is set only by truncation or in_error.

Test Plan:
1. Reset, then 32 bits 0x00000000 with in_clk every 8 cycles → 32 shift_clk pulses, store 2 cycles after the 32nd in_clk, pwm_set 3 cycles after, state=FORWARD, error=0.
2. 48-bit burst, own frame with correct parity, then 16 bits 0xA5C3 → fwd_clk x16 with fwd_data replaying 0xA5C3 at 1-cycle latency; fwd_enable drops 64 idle cycles after the last in_clk; state=IDLE.
3. Own frame 0x00000001 (odd parity) → no store, no pwm_set, error=1, following bits still forwarded (with FRAME_SEQ_PARITY_EN defined).
4. 20 bits then silence → error=1 at timeout, no store, state=IDLE; a next valid 32-bit frame clears error and stores.
5. in_error asserted together with the 40th in_clk → that bit is not forwarded, state=ERROR, fwd_enable=0, no further fwd_clk until timeout.
6. rst_n pulsed low in the cycle after the 32nd in_clk → all outputs 0 immediately, no store/pwm_set pulse, state=IDLE.
